// File: rtl/ensemble_axis_pipe_array.sv
// ensemble_axis_pipe_array: per-channel AXI-Stream skid-buffer register slices with frame counters.
// Define ENSEMBLE_PIPE_STATS_EN to build the saturating frame counters; otherwise frame_count reads 0.
module ensemble_axis_pipe_array #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_CH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_CH-1:0]              s_axis_tvalid,
    output logic [NUM_CH-1:0]              s_axis_tready,
    input  logic [NUM_CH-1:0]              s_axis_tlast,
    output logic [NUM_CH*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_CH*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [NUM_CH-1:0]              m_axis_tvalid,
    input  logic [NUM_CH-1:0]              m_axis_tready,
    output logic [NUM_CH-1:0]              m_axis_tlast,
    input  logic                           cnt_clr,
    output logic [NUM_CH*CNT_WIDTH-1:0]    frame_count
);
    localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t state;
        logic [W-1:0] main_q, skid_q, beat;
        logic valid_q, ready_q, s_acc, m_acc;
        assign beat = {s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH], s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH], s_axis_tlast[i]};
        assign s_acc = s_axis_tvalid[i] & ready_q;
        assign m_acc = valid_q & m_axis_tready[i];
        assign {m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH], m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH], m_axis_tlast[i]} = main_q;
        assign m_axis_tvalid[i] = valid_q;
        assign s_axis_tready[i] = ready_q;
        // valid_q and ready_q are kept as flops alongside state so neither is decoded combinationally
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= EMPTY;
                valid_q <= 1'b0;
                ready_q <= 1'b0;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        ready_q <= 1'b1;
                        if (s_acc) begin
                            main_q  <= beat;
                            valid_q <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (s_acc && m_acc) begin
                            main_q <= beat;
                        end else if (s_acc) begin
                            skid_q  <= beat;
                            ready_q <= 1'b0;
                            state   <= FULL;
                        end else if (m_acc) begin
                            valid_q <= 1'b0;
                            state   <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (m_acc) begin
                            main_q  <= skid_q;
                            ready_q <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= EMPTY;
                    end
                endcase
            end
        end
`ifdef ENSEMBLE_PIPE_STATS_EN
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (cnt_clr)
                cnt <= '0;
            else if (m_acc && main_q[0] && cnt != '1)
                cnt <= cnt + CNT_WIDTH'(1);
        end
        assign frame_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
`else
        assign frame_count[i*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
    end

`ifndef ENSEMBLE_PIPE_STATS_EN
    logic unused_clr;
    assign unused_clr = cnt_clr;
`endif
endmodule

// File: tb/tb_ensemble_axis_pipe_array.sv
// tb_ensemble_axis_pipe_array: scoreboard bench for the skid-slice array and its frame counters.
module tb_ensemble_axis_pipe_array;
    localparam int NC = 3, DW = 32, KW = 4, CW = 4, BW = DW + KW + 1;
`ifdef ENSEMBLE_PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef logic [BW-1:0] q_t[$];

    logic clk = 1'b0, rst_n = 1'b0, cnt_clr = 1'b0;
    logic [NC*DW-1:0] s_axis_tdata = '0, m_axis_tdata;
    logic [NC*KW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
    logic [NC-1:0] s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0;
    logic [NC-1:0] m_axis_tvalid, m_axis_tready = '0, m_axis_tlast;
    logic [NC*CW-1:0] frame_count;

    int checks = 0, errors = 0;
    q_t q[NC];
    logic [CW-1:0] exp_cnt[NC];
    logic [BW-1:0] prev[NC];
    logic hold[NC], sacc[NC];
    int idx[NC];

    ensemble_axis_pipe_array #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .cnt_clr(cnt_clr), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input int c, input int i, input int pkt, input int tid);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        d = {8'(c), 8'(tid), 16'(i)};
        k = KW'(i * 7 + c + 1);
        return {d, k, (i % pkt) == pkt - 1};
    endfunction

    task automatic drive(input int c, input logic v, input logic [BW-1:0] b);
        s_axis_tvalid[c] = v;
        {s_axis_tdata[c*DW +: DW], s_axis_tkeep[c*KW +: KW], s_axis_tlast[c]} = b;
    endtask

    // Scoreboard: beats accepted at the upcoming edge are pushed, beats leaving are popped and compared
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                q[c].delete();
                exp_cnt[c] = '0;
                hold[c] = 1'b0;
                sacc[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin : mon
                logic [BW-1:0] mo;
                mo = {m_axis_tdata[c*DW +: DW], m_axis_tkeep[c*KW +: KW], m_axis_tlast[c]};
                if (hold[c]) chk("stable", 64'(mo), 64'(prev[c]));
                chk("count", 64'(frame_count[c*CW +: CW]), 64'(exp_cnt[c]));
                if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                    if (q[c].size() == 0) chk("extra", 64'(q[c].size()), 64'd1);
                    else chk("beat", 64'(mo), 64'(q[c].pop_front()));
                    if (STATS && mo[0] && exp_cnt[c] != '1) exp_cnt[c] = exp_cnt[c] + 1'b1;
                end
                if (cnt_clr) exp_cnt[c] = '0;
                sacc[c] = s_axis_tvalid[c] && s_axis_tready[c];
                if (sacc[c]) q[c].push_back({s_axis_tdata[c*DW +: DW], s_axis_tkeep[c*KW +: KW], s_axis_tlast[c]});
                hold[c] = m_axis_tvalid[c] && !m_axis_tready[c];
                prev[c] = mo;
            end
        end
    end

    // mode 1: full-rate latency check, mode 2: ch1 stalled for cycles 8..11
    task automatic run(input int n, input int pkt, input int vp, input int rp, input int mode, input int tid);
        int cyc;
        bit done;
        cyc = 0;
        done = 1'b0;
        for (int c = 0; c < NC; c++) idx[c] = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            for (int c = 0; c < NC; c++) begin
                if (sacc[c]) idx[c]++;
                drive(c, idx[c] < n && $urandom_range(99) < vp, beat(c, idx[c], pkt, tid));
                m_axis_tready[c] = (mode == 2 && c == 1 && cyc >= 8 && cyc < 12) ? 1'b0 : $urandom_range(99) < rp;
            end
            @(negedge clk); #1;
            if (mode == 1) chk("stream_valid", 64'(m_axis_tvalid), (cyc >= 1 && cyc <= n) ? 64'h7 : 64'h0);
            if (mode == 2 && cyc == 8) chk("bp_ready_pre", 64'(s_axis_tready), 64'h7);
            if (mode == 2 && cyc >= 9 && cyc <= 12) chk("bp_ready", 64'(s_axis_tready), 64'h5);
            cyc++;
            done = 1'b1;
            for (int c = 0; c < NC; c++) if (idx[c] < n || q[c].size() != 0) done = 1'b0;
        end
        chk("timeout", 64'(done), 64'd1);
        s_axis_tvalid = '0;
        m_axis_tready = '1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (5) begin
            @(negedge clk); #1;
            chk("rst_sready", 64'(s_axis_tready), 64'h0);
            chk("rst_mvalid", 64'(m_axis_tvalid), 64'h0);
            chk("rst_count", 64'(frame_count), 64'h0);
        end
        chk("rst_mdata", 64'(m_axis_tdata), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_sready", 64'(s_axis_tready), 64'h7);

        run(16, 16, 100, 100, 1, 1);
        for (int c = 0; c < NC; c++) chk("stream_cnt", 64'(frame_count[c*CW +: CW]), STATS ? 64'd1 : 64'd0);
        run(16, 16, 100, 100, 2, 2);
        run(1000, 7, 50, 50, 0, 3);

        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        run(20, 1, 100, 100, 0, 4);
        for (int c = 0; c < NC; c++) chk("sat_cnt", 64'(frame_count[c*CW +: CW]), STATS ? 64'd15 : 64'd0);
        for (int c = 0; c < NC; c++) drive(c, 1'b1, beat(c, 0, 1, 5));
        @(posedge clk); #1;
        s_axis_tvalid = '0;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_cnt", 64'(frame_count), 64'h0);
        @(posedge clk); #1;

        m_axis_tready = '0;
        drive(0, 1'b1, beat(0, 0, 4, 6));
        @(posedge clk); #1;
        drive(0, 1'b1, beat(0, 1, 4, 6));
        @(posedge clk); #1;
        s_axis_tvalid = '0;
        chk("full_sready", 64'(s_axis_tready[0]), 64'd0);
        chk("full_mvalid", 64'(m_axis_tvalid[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("async_sready", 64'(s_axis_tready), 64'h0);
        m_axis_tready = '1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel2_sready", 64'(s_axis_tready), 64'h7);
        run(8, 8, 100, 100, 0, 7);
        for (int c = 0; c < NC; c++) chk("post_cnt", 64'(frame_count[c*CW +: CW]), STATS ? 64'd1 : 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
